// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag_serial_tx: bit-serial bsg_tag packet transmitter for a bsg_tag_master
// data/enable pair. Sends header+payload packets or a master-reset ones burst,
// always followed by a run of idle gap cycles.
// Optional build macro BSG_TAG_TX_ZERO_LEN_DROP_EN: zero-length data commands
// are accepted and discarded instead of being sent as header-only packets.
module bsg_tag_serial_tx #(
   parameter int els_p        = 16,
   parameter int lg_width_p   = 4,
   parameter int reset_ones_p = 32,
   parameter int gap_p        = 2,
   localparam int lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int pay_w_lp    = (2 ** lg_width_p) - 1
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  v_i,
   output logic                  ready_o,
   input  logic                  master_reset_i,
   input  logic [lg_els_lp-1:0]  id_i,
   input  logic                  data_not_reset_i,
   input  logic [lg_width_p-1:0] len_i,
   input  logic [pay_w_lp-1:0]   payload_i,
   output logic                  tag_data_o,
   output logic                  tag_en_o
);

   localparam int hdr_len_lp = 2 + lg_els_lp + lg_width_p;
   localparam int max_a_lp   = (hdr_len_lp > pay_w_lp) ? hdr_len_lp : pay_w_lp;
   localparam int max_b_lp   = (reset_ones_p > gap_p) ? reset_ones_p : gap_p;
   localparam int max_cnt_lp = (max_a_lp > max_b_lp) ? max_a_lp : max_b_lp;
   localparam int cnt_w_lp   = $clog2(max_cnt_lp + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      PAY  = 3'd2,
      RST  = 3'd3,
      GAP  = 3'd4
   } state_e;

   state_e                 state;
   logic [cnt_w_lp-1:0]    cnt;
   logic [hdr_len_lp-1:0]  hdr_sr;
   logic [pay_w_lp-1:0]    pay_sr;
   logic [lg_width_p-1:0]  len_r;
   logic                   accept;
   logic                   drop_zero_len;

   // Ready is a pure function of state, held low while reset is asserted.
   assign ready_o = (state == IDLE) & reset_n_i;
   assign accept  = v_i & ready_o;

`ifdef BSG_TAG_TX_ZERO_LEN_DROP_EN
   assign drop_zero_len = ~master_reset_i & (len_i == '0);
`else
   assign drop_zero_len = 1'b0;
`endif

   // Command capture and serial shift registers; header is packed so bit 0 goes out first.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         hdr_sr <= {len_i, data_not_reset_i, id_i, 1'b1};
         pay_sr <= payload_i;
         len_r  <= len_i;
      end else if (state == HDR) begin
         hdr_sr <= hdr_sr >> 1;
      end else if (state == PAY) begin
         pay_sr <= pay_sr >> 1;
      end
   end

   // Sequencing FSM with registered serial outputs, one bit per cycle.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state      <= IDLE;
         cnt        <= '0;
         tag_data_o <= 1'b0;
         tag_en_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tag_data_o <= 1'b0;
               tag_en_o   <= 1'b0;
               cnt        <= '0;
               if (accept) begin
                  if (master_reset_i)     state <= RST;
                  else if (drop_zero_len) state <= GAP;
                  else                    state <= HDR;
               end
            end
            HDR: begin
               tag_data_o <= hdr_sr[0];
               tag_en_o   <= 1'b1;
               if (cnt == cnt_w_lp'(hdr_len_lp - 1)) begin
                  cnt   <= '0;
                  state <= (len_r != '0) ? PAY : GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PAY: begin
               tag_data_o <= pay_sr[0];
               tag_en_o   <= 1'b1;
               if ((cnt + 1'b1) == cnt_w_lp'(len_r)) begin
                  cnt   <= '0;
                  state <= GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RST: begin
               tag_data_o <= 1'b1;
               tag_en_o   <= 1'b1;
               if (cnt == cnt_w_lp'(reset_ones_p - 1)) begin
                  cnt   <= '0;
                  state <= GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               tag_data_o <= 1'b0;
               tag_en_o   <= 1'b0;
               if (cnt == cnt_w_lp'(gap_p - 1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               tag_data_o <= 1'b0;
               tag_en_o   <= 1'b0;
               cnt        <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// Directed bench for bsg_tag_serial_tx at default parameters. Each capture
// records en/data/ready for cycles 1..n after the accepting edge into vectors
// (cycle k -> bit k-1) which are compared against hand-derived constants.
module tb_bsg_tag_serial_tx;

   localparam int lg_els_lp  = 4;
   localparam int lg_width_p = 4;
   localparam int pay_w_lp   = 15;

   logic                  clk_i = 1'b0;
   logic                  reset_n_i = 1'b0;
   logic                  v_i = 1'b0;
   logic                  ready_o;
   logic                  master_reset_i = 1'b0;
   logic [lg_els_lp-1:0]  id_i = '0;
   logic                  data_not_reset_i = 1'b0;
   logic [lg_width_p-1:0] len_i = '0;
   logic [pay_w_lp-1:0]   payload_i = '0;
   logic                  tag_data_o;
   logic                  tag_en_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] en_v, dat_v, rdy_v;

   bsg_tag_serial_tx dut (
      .clk_i            (clk_i),
      .reset_n_i        (reset_n_i),
      .v_i              (v_i),
      .ready_o          (ready_o),
      .master_reset_i   (master_reset_i),
      .id_i             (id_i),
      .data_not_reset_i (data_not_reset_i),
      .len_i            (len_i),
      .payload_i        (payload_i),
      .tag_data_o       (tag_data_o),
      .tag_en_o         (tag_en_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Wait (bounded) for ready, present a command and let one edge accept it.
   task automatic send(input logic mr, input logic [3:0] id, input logic dnr,
                       input logic [3:0] len, input logic [14:0] pay);
      int waited;
      waited = 0;
      @(negedge clk_i);
      while (!ready_o && waited < 200) begin
         @(negedge clk_i);
         waited++;
      end
      check_eq("ready_before_send", 64'(ready_o), 64'd1);
      master_reset_i   = mr;
      id_i             = id;
      data_not_reset_i = dnr;
      len_i            = len;
      payload_i        = pay;
      v_i              = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   // Record n cycles after the accepting edge; optionally scramble inputs.
   task automatic capture(input int n, input bit scramble, input int vdrop);
      en_v  = '0;
      dat_v = '0;
      rdy_v = '0;
      if (vdrop == 0) v_i = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         en_v[k-1]  = tag_en_o;
         dat_v[k-1] = tag_data_o;
         rdy_v[k-1] = ready_o;
         if (scramble) begin
            master_reset_i   = 1'($urandom);
            id_i             = 4'($urandom);
            data_not_reset_i = 1'($urandom);
            len_i            = 4'($urandom);
            payload_i        = 15'($urandom);
         end
         if (k == vdrop) v_i = 1'b0;
      end
      master_reset_i = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk_i);
      check_eq("rst_en", 64'(tag_en_o), 64'd0);
      check_eq("rst_data", 64'(tag_data_o), 64'd0);
      check_eq("rst_ready", 64'(ready_o), 64'd0);
      reset_n_i = 1'b1;
      @(negedge clk_i);
      check_eq("ready_after_rst", 64'(ready_o), 64'd1);

      // Data packet id=5 dnr=1 len=3 payload=101
      send(1'b0, 4'd5, 1'b1, 4'd3, 15'b101);
      capture(16, 1'b0, 0);
      check_eq("pkt_en", en_v, 64'h1FFF);
      check_eq("pkt_data", dat_v, 64'h14EB);
      check_eq("pkt_ready", rdy_v, 64'hC000);

      // Master reset burst, other fields random
      send(1'b1, 4'($urandom), 1'($urandom), 4'($urandom), 15'($urandom));
      capture(35, 1'b0, 0);
      check_eq("mrst_en", en_v, 64'hFFFF_FFFF);
      check_eq("mrst_data", dat_v, 64'hFFFF_FFFF);
      check_eq("mrst_ready", rdy_v, 64'h6_0000_0000);

      // Maximum length, inputs scrambled while the packet is in flight
      send(1'b0, 4'd15, 1'b0, 4'd15, 15'h5A5A);
      capture(28, 1'b1, 0);
      check_eq("max_en", en_v, 64'h1FF_FFFF);
      check_eq("max_data", dat_v, 64'h169_6BDF);
      check_eq("max_ready", rdy_v, 64'hC00_0000);

      // Zero-length data command
      send(1'b0, 4'd3, 1'b1, 4'd0, 15'h7FFF);
      capture(13, 1'b0, 0);
`ifdef BSG_TAG_TX_ZERO_LEN_DROP_EN
      check_eq("zlen_en", en_v, 64'h0);
      check_eq("zlen_data", dat_v, 64'h0);
      check_eq("zlen_ready", rdy_v, 64'h1FFE);
`else
      check_eq("zlen_en", en_v, 64'h3FF);
      check_eq("zlen_data", dat_v, 64'h27);
      check_eq("zlen_ready", rdy_v, 64'h1800);
`endif

      // Back-to-back with v held high: A then B, B fields applied after A's accept
      send(1'b0, 4'd1, 1'b1, 4'd1, 15'h1);
      id_i             = 4'd2;
      data_not_reset_i = 1'b0;
      len_i            = 4'd2;
      payload_i        = 15'b10;
      capture(30, 1'b0, 14);
      check_eq("b2b_en", en_v, 64'h3FF_C7FF);
      check_eq("b2b_data", dat_v, 64'h221_4463);
      check_eq("b2b_ready", rdy_v, 64'h3800_1000);

      // Asynchronous reset during payload bit 2
      send(1'b0, 4'd5, 1'b1, 4'd3, 15'b101);
      capture(12, 1'b0, 0);
      @(posedge clk_i);
      #1;
      check_eq("midrst_en_pre", 64'(tag_en_o), 64'd1);
      check_eq("midrst_data_pre", 64'(tag_data_o), 64'd1);
      #1 reset_n_i = 1'b0;
      #1;
      check_eq("midrst_en", 64'(tag_en_o), 64'd0);
      check_eq("midrst_data", 64'(tag_data_o), 64'd0);
      check_eq("midrst_ready", 64'(ready_o), 64'd0);
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
      @(negedge clk_i);
      check_eq("midrst_ready_after", 64'(ready_o), 64'd1);
      send(1'b0, 4'd5, 1'b1, 4'd3, 15'b101);
      capture(16, 1'b0, 0);
      check_eq("post_rst_en", en_v, 64'h1FFF);
      check_eq("post_rst_data", dat_v, 64'h14EB);
      check_eq("post_rst_ready", rdy_v, 64'hC000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time limit so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish before time limit");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "time limit");
   end

endmodule
